// File: rtl/prog_loader_if.sv
// Byte-source and program-memory write bundle for the loader.
// master = loader side, slave = byte source / memory / CPU side.
interface prog_loader_if #(
   parameter int ADDR_WIDTH = 16
);
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [15:0]           mem_data_in;
   logic                  mem_write_enable;
   logic                  cpu_hold;
   logic                  done;
   logic                  error;

   modport master (
      input  in_data,
      input  in_valid,
      output in_ready,
      output mem_address,
      output mem_data_in,
      output mem_write_enable,
      output cpu_hold,
      output done,
      output error
   );

   modport slave (
      output in_data,
      output in_valid,
      input  in_ready,
      input  mem_address,
      input  mem_data_in,
      input  mem_write_enable,
      input  cpu_hold,
      input  done,
      input  error
   );
endinterface

// File: rtl/prog_loader.sv
// Byte-stream program loader: SYNC, LEN, N words, XOR checksum.
// Holds the CPU in reset until a verified image has been written.
module prog_loader #(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter logic [7:0]            SYNC_BYTE  = 8'hA5
) (
   input logic           clk,
   input logic           reset,
   prog_loader_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            len_hi_q, len_hi_d;
   logic [7:0]            hi_q, hi_d;
   logic [7:0]            xor_q, xor_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic                  hold_q, hold_d;
   logic                  err_q, err_d;

   logic                  acc;
   logic [15:0]           len_w;

   assign bus.in_ready         = (state_q != S_DONE);
   assign acc                  = bus.in_valid & bus.in_ready;
   assign len_w                = {len_hi_q, bus.in_data};
   assign bus.mem_address      = addr_q;
   assign bus.mem_data_in      = wdata_q;
   assign bus.mem_write_enable = we_q;
   assign bus.cpu_hold         = hold_q;
   assign bus.done             = (state_q == S_DONE);
   assign bus.error            = err_q;

   // State and datapath registers; reset aborts any frame at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         len_hi_q <= '0;
         hi_q     <= '0;
         xor_q    <= '0;
         cnt_q    <= '0;
         addr_q   <= BASE_ADDR;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         hold_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_hi_q <= len_hi_d;
         hi_q     <= hi_d;
         xor_q    <= xor_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         hold_q   <= hold_d;
         err_q    <= err_d;
      end
   end

   // Frame parser: next state, write strobe, checksum and hold control.
   always_comb begin
      state_d  = state_q;
      len_hi_d = len_hi_q;
      hi_d     = hi_q;
      xor_d    = xor_q;
      cnt_d    = cnt_q;
      wdata_d  = wdata_q;
      we_d     = 1'b0;
      hold_d   = hold_q;
      err_d    = err_q;
      // address steps on the edge where the strobe drops
      addr_d   = we_q ? addr_q + ADDR_WIDTH'(1) : addr_q;

      if (state_q == S_DONE) begin
         state_d = S_IDLE;
      end else if (acc) begin
         unique case (state_q)
            S_IDLE, S_ERROR: begin
               if (bus.in_data == SYNC_BYTE) begin
                  state_d = S_LEN_HI;
                  err_d   = 1'b0;
                  xor_d   = '0;
                  addr_d  = BASE_ADDR;
                  hold_d  = 1'b1;
               end
            end
            S_LEN_HI: begin
               len_hi_d = bus.in_data;
               state_d  = S_LEN_LO;
            end
            S_LEN_LO: begin
               cnt_d   = len_w;
               state_d = (len_w == 16'd0) ? S_CHECK : S_DATA_HI;
            end
            S_DATA_HI: begin
               hi_d    = bus.in_data;
               xor_d   = xor_q ^ bus.in_data;
               state_d = S_DATA_LO;
            end
            S_DATA_LO: begin
               wdata_d = {hi_q, bus.in_data};
               we_d    = 1'b1;
               xor_d   = xor_q ^ bus.in_data;
               cnt_d   = cnt_q - 16'd1;
               state_d = (cnt_q == 16'd1) ? S_CHECK : S_DATA_HI;
            end
            S_CHECK: begin
               if (bus.in_data == xor_q) begin
                  state_d = S_DONE;
                  hold_d  = 1'b0;
               end else begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of frames plus
// hand sequences for garbage, address wrap and mid-frame reset.
module tb_prog_loader;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   prog_loader_if #(.ADDR_WIDTH(16)) bus ();
   prog_loader_if #(.ADDR_WIDTH(4))  bus2 ();

   assign bus2.in_data  = bus.in_data;
   assign bus2.in_valid = bus.in_valid;

   prog_loader #(
      .ADDR_WIDTH(16),
      .BASE_ADDR (16'h0000),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.master)
   );

   prog_loader #(
      .ADDR_WIDTH(4),
      .BASE_ADDR (4'hF),
      .SYNC_BYTE (8'hA5)
   ) dut2 (
      .clk  (clk),
      .reset(reset),
      .bus  (bus2.master)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0]  b[10];
      int          nb;
      int          gap;
      int          nw;
      logic [15:0] wa[3];
      logic [15:0] wd[3];
      int          nd;
      logic        err;
      logic        hold;
   } vec_t;

   vec_t tv[8];

   logic [31:0] wq[$];
   logic [31:0] wq2[$];
   int          done_cnt = 0;
   logic        we_prev = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         we_prev = 1'b0;
      end else begin
         if (bus.mem_write_enable) begin
            wq.push_back({bus.mem_address, bus.mem_data_in});
            chk("strobe_width", {31'd0, we_prev}, 32'd0);
         end
         we_prev = bus.mem_write_enable;
         if (bus.done) begin
            done_cnt++;
            chk("hold_at_done", {31'd0, bus.cpu_hold}, 32'd0);
            chk("ready_at_done", {31'd0, bus.in_ready}, 32'd0);
         end
         if (bus2.mem_write_enable)
            wq2.push_back({12'h0, bus2.mem_address, bus2.mem_data_in});
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) chk("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic apply(input int i);
      wq.delete();
      done_cnt = 0;
      for (int j = 0; j < tv[i].nb; j++) begin
         send_byte(tv[i].b[j]);
         if (j == 0) begin
            #1 chk("hold_after_sync", {31'd0, bus.cpu_hold}, 32'd1);
         end
         if (tv[i].gap > 0) idle(tv[i].gap);
      end
      idle(3);
      chk("nwrites", wq.size(), tv[i].nw);
      for (int k = 0; k < tv[i].nw; k++) begin
         if (k < wq.size()) begin
            chk("waddr", {16'h0, wq[k][31:16]}, {16'h0, tv[i].wa[k]});
            chk("wdata", {16'h0, wq[k][15:0]}, {16'h0, tv[i].wd[k]});
         end
      end
      chk("ndone", done_cnt, tv[i].nd);
      chk("error", {31'd0, bus.error}, {31'd0, tv[i].err});
      chk("hold", {31'd0, bus.cpu_hold}, {31'd0, tv[i].hold});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0].b    = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34,
                     8'hAB, 8'hCD, 8'h40, 8'h00, 8'h00};
      tv[0].nb   = 8;  tv[0].gap = 0; tv[0].nw = 2;
      tv[0].wa   = '{16'h0000, 16'h0001, 16'h0000};
      tv[0].wd   = '{16'h1234, 16'hABCD, 16'h0000};
      tv[0].nd   = 1;  tv[0].err = 1'b0; tv[0].hold = 1'b0;

      tv[1]      = tv[0];
      tv[1].b[7] = 8'h41;
      tv[1].nd   = 0;  tv[1].err = 1'b1; tv[1].hold = 1'b1;

      tv[2]      = tv[0];

      tv[3].b    = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tv[3].nb   = 4;  tv[3].gap = 0; tv[3].nw = 0;
      tv[3].wa   = '{16'h0, 16'h0, 16'h0};
      tv[3].wd   = '{16'h0, 16'h0, 16'h0};
      tv[3].nd   = 1;  tv[3].err = 1'b0; tv[3].hold = 1'b0;

      tv[4]      = tv[3];
      tv[4].b[3] = 8'h01;
      tv[4].nd   = 0;  tv[4].err = 1'b1; tv[4].hold = 1'b1;

      tv[5].b    = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'h5A,
                     8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
      tv[5].nb   = 6;  tv[5].gap = 0; tv[5].nw = 1;
      tv[5].wa   = '{16'h0000, 16'h0, 16'h0};
      tv[5].wd   = '{16'hA55A, 16'h0, 16'h0};
      tv[5].nd   = 1;  tv[5].err = 1'b0; tv[5].hold = 1'b0;

      tv[6]      = tv[0];
      tv[6].gap  = 2;

      tv[7].b    = '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h02,
                     8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      tv[7].nb   = 10; tv[7].gap = 0; tv[7].nw = 3;
      tv[7].wa   = '{16'h0000, 16'h0001, 16'h0002};
      tv[7].wd   = '{16'h0102, 16'h0304, 16'h0506};
      tv[7].nd   = 1;  tv[7].err = 1'b0; tv[7].hold = 1'b0;

      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_we", {31'd0, bus.mem_write_enable}, 32'd0);
      chk("rst_addr", {16'h0, bus.mem_address}, 32'h0);
      chk("rst_data", {16'h0, bus.mem_data_in}, 32'h0);
      chk("rst_hold", {31'd0, bus.cpu_hold}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_error", {31'd0, bus.error}, 32'd0);
      chk("rst_addr_w4", {28'h0, bus2.mem_address}, 32'hF);

      wq.delete();
      send_byte(8'h00);
      #1 chk("garbage_hold", {31'd0, bus.cpu_hold}, 32'd0);
      send_byte(8'hFF);
      #1 chk("garbage_hold", {31'd0, bus.cpu_hold}, 32'd0);
      send_byte(8'h13);
      #1 chk("garbage_hold", {31'd0, bus.cpu_hold}, 32'd0);
      idle(2);
      chk("garbage_writes", wq.size(), 0);

      for (int i = 0; i < 8; i++) apply(i);

      wq2.delete();
      apply(0);
      chk("wrap_nwrites", wq2.size(), 2);
      if (wq2.size() == 2) begin
         chk("wrap_addr0", {16'h0, wq2[0][31:16]}, 32'hF);
         chk("wrap_addr1", {16'h0, wq2[1][31:16]}, 32'h0);
         chk("wrap_data1", {16'h0, wq2[1][15:0]}, 32'hABCD);
      end

      wq.delete();
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h04);
      send_byte(8'h11);
      send_byte(8'h22);
      idle(2);
      chk("mid_writes", wq.size(), 1);
      chk("mid_addr_step", {16'h0, bus.mem_address}, 32'h1);
      chk("mid_hold", {31'd0, bus.cpu_hold}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst_hold", {31'd0, bus.cpu_hold}, 32'd0);
      chk("arst_we", {31'd0, bus.mem_write_enable}, 32'd0);
      chk("arst_addr", {16'h0, bus.mem_address}, 32'h0);
      chk("arst_data", {16'h0, bus.mem_data_in}, 32'h0);
      chk("arst_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("arst_error", {31'd0, bus.error}, 32'd0);
      chk("arst_done", {31'd0, bus.done}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      apply(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that writes 16-bit instruction words into the CPU's program memory through that memory's write port. It sits between an external byte source (UART receiver, debug bridge) and `memory`, and drives the write side that the CPU fetch path never uses. While loading it holds the CPU in reset via `cpu_hold`. It releases the CPU only after a checksum-verified image has been written.

## Interface
- `ADDR_WIDTH`, 16: width of the program-memory address.
- `BASE_ADDR`, 16'h0000: address of the first word written.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_data` in 8: incoming byte.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: loader accepts the byte this cycle. A byte transfers when `in_valid & in_ready`.
- `mem_address` out ADDR_WIDTH: write address to program memory.
- `mem_data_in` out 16: write data.
- `mem_write_enable` out 1: one-cycle write strobe.
- `cpu_hold` out 1: OR into the CPU reset; high while a frame is in progress.
- `done` out 1: one-cycle pulse when a frame completes with a good checksum.
- `error` out 1: sticky checksum-failure flag.

## Operation
- Frame format: `SYNC_BYTE`, then LEN_HI, LEN_LO (16-bit word count N), then N words each sent as high byte then low byte, then CHK. CHK is the XOR of all 2N data bytes; it excludes the sync and length bytes.
- States and transitions (each transition occurs on an accepted byte unless noted):
  - IDLE: a byte equal to `SYNC_BYTE` goes to LEN_HI. Any other byte is discarded.
  - LEN_HI goes to LEN_LO.
  - LEN_LO goes to DATA_HI if N≠0, or to CHECK if N=0.
  - DATA_HI latches the high byte and goes to DATA_LO.
  - DATA_LO assembles the word, issues the write, and decrements the remaining count. It goes to DATA_HI if the remaining count is nonzero after the decrement, otherwise to CHECK.
  - CHECK: if the byte equals the running XOR, go to DONE; otherwise go to ERROR.
  - DONE: unconditional, one cycle, then IDLE.
  - ERROR: behaves like IDLE, so a sync byte goes to LEN_HI. `error` stays set.
- Sync acceptance (from IDLE or ERROR) does the following:
  - Clears `error` and the running XOR.
  - Loads the address counter with `BASE_ADDR`.
  - Asserts `cpu_hold`.
- `cpu_hold` stays high through the rest of the frame and deasserts on entry to DONE.
  - On a checksum failure it stays high in ERROR, so the CPU never runs a bad image.
- Address counter increments by 1 after each write and wraps modulo 2^ADDR_WIDTH. No overflow flag.
- `in_ready` is 1 in every state except DONE.
- A sync-valued byte received inside a frame is treated as data or length. There is no resync mid-frame.

## Timing
- Reset values:
  - State is IDLE.
  - `in_ready`=1.
  - `mem_write_enable`=0, `mem_address`=BASE_ADDR, `mem_data_in`=0.
  - `cpu_hold`=0, `done`=0, `error`=0.
- Write latency:
  - `mem_write_enable`, `mem_address` and `mem_data_in` are registered outputs.
  - The strobe is high for exactly the one cycle after the low byte is accepted, carrying the address of that word.
  - The address counter advances on the same edge the strobe drops.
- Back-to-back bytes every cycle are supported, giving at most one write every 2 cycles.
- `done` is high in the cycle after CHK is accepted, and `cpu_hold` is low in that same cycle.
- `error` rises in the cycle after a bad CHK is accepted.
- When `in_valid` is low, no state changes occur and no writes are issued.
- Reset asserted mid-frame aborts immediately: no further writes, `cpu_hold` drops, and any partial image in memory is left as written.

## Test plan
- Frame A5 00 02 12 34 AB CD 40 with BASE_ADDR=0 -> writes 0x1234@0 and 0xABCD@1. `done` pulses once, `error`=0, and `cpu_hold` is high from the cycle after A5 until `done`.
- Same frame but CHK=41 -> both writes occur, `error`=1, no `done`, `cpu_hold` stays 1. A following good frame clears `error` and pulses `done`.
- Frame A5 00 00 00 -> no writes and `done` pulses. Frame A5 00 00 01 -> `error`=1.
- Bytes 00 FF 13 before A5 -> no writes, `cpu_hold` stays 0, and the later frame loads correctly.
- ADDR_WIDTH=4, BASE_ADDR=15, N=2 -> writes at addresses 15 then 0.
- `reset` pulsed after LEN_LO in a 4-word frame -> all outputs return to reset values within the same cycle, and a fresh frame then loads normally.
